// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {SEL_A, SEL_B} sel_t;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way grant select. With RAM_ARB_ROUND_ROBIN_EN a pointer resolves ties and
// flips to the losing side after every grant; without it A always wins ties.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic grant_en,
    output sel_t gnt
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    sel_t ptr;

    always_comb begin
        gnt = SEL_A;
        if (req_a && req_b) gnt = ptr;
        else if (req_b)     gnt = SEL_B;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ptr <= SEL_A;
        else if (grant_en) ptr <= (gnt == SEL_A) ? SEL_B : SEL_A;
    end
`else
    always_comb begin
        gnt = (!req_a && req_b) ? SEL_B : SEL_A;
    end

    logic unused_rr;
    assign unused_rr = clk ^ rst_n ^ grant_en;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one registered-read RAM port, one transaction
// per 3 cycles. Optional feature macro: RAM_ARB_ROUND_ROBIN_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    sel_t              sel;
    sel_t              gnt;
    logic              we_lat;
    logic              grant_en;
    logic [DATA_W-1:0] rd_a_q;
    logic [DATA_W-1:0] rd_b_q;

    assign grant_en = (state == IDLE) && (req_a || req_b);

    ram_arb_rr u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .grant_en (grant_en),
        .gnt      (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= SEL_A;
            we_lat    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    ack_a  <= 1'b0;
                    ack_b  <= 1'b0;
                    if (grant_en) begin
                        sel       <= gnt;
                        we_lat    <= (gnt == SEL_A) ? we_a    : we_b;
                        mem_we    <= (gnt == SEL_A) ? we_a    : we_b;
                        mem_addr  <= (gnt == SEL_A) ? addr_a  : addr_b;
                        mem_wdata <= (gnt == SEL_A) ? wdata_a : wdata_b;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    ack_a  <= (sel == SEL_A);
                    ack_b  <= (sel == SEL_B);
                    state  <= RESP;
                end
                RESP: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    if (!we_lat && sel == SEL_A) rd_a_q <= mem_rdata;
                    if (!we_lat && sel == SEL_B) rd_b_q <= mem_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM data only arrives in the ack cycle, so it is bypassed there and
    // captured into the holding register for the cycles that follow.
    assign rdata_a = (ack_a && !we_lat) ? mem_rdata : rd_a_q;
    assign rdata_b = (ack_b && !we_lat) ? mem_rdata : rd_b_q;

endmodule
